// File: rtl/dmem_arbiter.sv
// Two-port arbiter sharing the single-port data RAM between the core (port 0) and debug/loader
// (port 1). Define DMEM_ARB_FIXED_PRIO_EN to make port 1 always win on conflict.
module dmem_arbiter #(
  parameter int unsigned AW = 16,
  parameter int unsigned DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  // Port 0: core load/store
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [3:0]    be0,
  input  logic [DW-1:0] wdata0,
  output logic          gnt0,
  output logic          rvalid0,
  output logic [DW-1:0] rdata0,
  // Port 1: debug/loader
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [3:0]    be1,
  input  logic [DW-1:0] wdata1,
  output logic          gnt1,
  output logic          rvalid1,
  output logic [DW-1:0] rdata1,
  // RAM command
  output logic          ram_en,
  output logic          ram_we,
  output logic [AW-3:0] ram_addr,
  output logic [3:0]    ram_be,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata,
  output logic          err
);

  function automatic logic is_misaligned(input logic [1:0] lsb, input logic [3:0] be);
    logic mis;
    mis = 1'b0;
    if (be == 4'b1111) begin
      mis = (lsb != 2'b00);
    end else if (be == 4'b0011 || be == 4'b1100) begin
      mis = lsb[0];
    end
    return mis;
  endfunction

  logic          any_gnt;
  logic          sel_we;
  logic [AW-1:0] sel_addr;
  logic [3:0]    sel_be;
  logic [DW-1:0] sel_wdata;
  logic          sel_mis;
  logic          sel_bad;

  logic          pend_q, pend_d;
  logic          owner_q, owner_d;
  logic          zero_q, zero_d;
  logic          err_q, err_d;
  logic [DW-1:0] rdata0_q, rdata0_d;
  logic [DW-1:0] rdata1_q, rdata1_d;
  logic [DW-1:0] ret_data;

`ifdef DMEM_ARB_FIXED_PRIO_EN
  // Loader traffic always wins; the core simply stalls while req1 is high.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (rst_n) begin
      gnt1 = req1;
      gnt0 = req0 & ~req1;
    end
  end
`else
  logic prio_q, prio_d;

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (rst_n) begin
      if (req0 && req1) begin
        gnt0 = ~prio_q;
        gnt1 = prio_q;
      end else begin
        gnt0 = req0;
        gnt1 = req1;
      end
    end
  end

  // Round-robin: the port just served drops to lower priority.
  always_comb begin
    prio_d = prio_q;
    if (gnt0) begin
      prio_d = 1'b1;
    end else if (gnt1) begin
      prio_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_q <= 1'b0;
    end else begin
      prio_q <= prio_d;
    end
  end
`endif

  assign any_gnt = gnt0 | gnt1;

  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_be    = '0;
    sel_wdata = '0;
    if (gnt1) begin
      sel_we    = we1;
      sel_addr  = addr1;
      sel_be    = be1;
      sel_wdata = wdata1;
    end else if (gnt0) begin
      sel_we    = we0;
      sel_addr  = addr0;
      sel_be    = be0;
      sel_wdata = wdata0;
    end
  end

  assign sel_mis = is_misaligned(sel_addr[1:0], sel_be);
  // Misaligned and empty-lane accesses complete the handshake but never touch the RAM.
  assign sel_bad = sel_mis | (sel_be == 4'b0000);

  assign ram_en    = any_gnt & ~sel_bad;
  assign ram_we    = sel_we;
  assign ram_addr  = sel_addr[AW-1:2];
  assign ram_be    = sel_be;
  assign ram_wdata = sel_wdata;

  always_comb begin
    pend_d  = any_gnt & ~sel_we;
    owner_d = owner_q;
    if (any_gnt && !sel_we) begin
      owner_d = gnt1;
    end
    zero_d = sel_bad;
    err_d  = any_gnt & sel_mis;
  end

  assign ret_data = zero_q ? '0 : ram_rdata;

  always_comb begin
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    if (pend_q && !owner_q) begin
      rdata0_d = ret_data;
    end
    if (pend_q && owner_q) begin
      rdata1_d = ret_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q   <= 1'b0;
      owner_q  <= 1'b0;
      zero_q   <= 1'b0;
      err_q    <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      pend_q   <= pend_d;
      owner_q  <= owner_d;
      zero_q   <= zero_d;
      err_q    <= err_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  // RAM data is forwarded in the return cycle and held afterwards.
  assign rvalid0 = pend_q & ~owner_q;
  assign rvalid1 = pend_q & owner_q;
  assign rdata0  = rdata0_d;
  assign rdata1  = rdata1_d;
  assign err     = err_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with a small behavioural RAM.
module tb_dmem_arbiter;
  localparam int unsigned AW = 16;
  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req0, we0, req1, we1;
  logic [AW-1:0] addr0, addr1;
  logic [3:0]    be0, be1;
  logic [DW-1:0] wdata0, wdata1;
  logic          gnt0, gnt1, rvalid0, rvalid1;
  logic [DW-1:0] rdata0, rdata1;
  logic          ram_en, ram_we, err;
  logic [AW-3:0] ram_addr;
  logic [3:0]    ram_be;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata = '0;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [64];

  always #5 clk = ~clk;

  dmem_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .we0(we0), .addr0(addr0), .be0(be0), .wdata0(wdata0),
    .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .be1(be1), .wdata1(wdata1),
    .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_be(ram_be),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .err(err)
  );

  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) begin
        for (int b = 0; b < 4; b++) begin
          if (ram_be[b]) mem[ram_addr[5:0]][b*8 +: 8] <= ram_wdata[b*8 +: 8];
        end
      end else begin
        ram_rdata <= mem[ram_addr[5:0]];
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req0 = 1'b0; we0 = 1'b0; addr0 = '0; be0 = 4'hF; wdata0 = '0;
    req1 = 1'b0; we1 = 1'b0; addr1 = '0; be1 = 4'hF; wdata1 = '0;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle();
    req0 = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (gnt0 !== 1'b0) begin errors++; $display("FAIL rst_gnt0 got %b want 0", gnt0); end
    checks++; if (ram_en !== 1'b0) begin errors++; $display("FAIL rst_ram_en got %b want 0", ram_en); end
    checks++; if ({rvalid0, rvalid1, err} !== 3'b000) begin
      errors++; $display("FAIL rst_rvalid_err got %b want 000", {rvalid0, rvalid1, err}); end
    checks++; if (rdata0 !== 32'h0) begin errors++; $display("FAIL rst_rdata0 got %h want 0", rdata0); end
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (gnt0 !== 1'b1) begin errors++; $display("FAIL rst_rel_gnt0 got %b want 1", gnt0); end
    tick();
    idle();
    tick();
  endtask

  task automatic test_single_read();
    idle();
    req0 = 1'b1; addr0 = 16'h0010;
    @(negedge clk);
    checks++; if (gnt0 !== 1'b1) begin errors++; $display("FAIL rd_gnt0 got %b want 1", gnt0); end
    checks++; if (ram_addr !== 14'h0004) begin
      errors++; $display("FAIL rd_ram_addr got %h want 0004", ram_addr); end
    checks++; if ({ram_en, ram_we} !== 2'b10) begin
      errors++; $display("FAIL rd_ram_cmd got %b want 10", {ram_en, ram_we}); end
    tick();
    idle();
    @(negedge clk);
    checks++; if (rvalid0 !== 1'b1) begin errors++; $display("FAIL rd_rvalid0 got %b want 1", rvalid0); end
    checks++; if (rdata0 !== 32'hDEADBEEF) begin
      errors++; $display("FAIL rd_rdata0 got %h want deadbeef", rdata0); end
    checks++; if (rvalid1 !== 1'b0) begin errors++; $display("FAIL rd_rvalid1 got %b want 0", rvalid1); end
    tick();
    @(negedge clk);
    checks++; if (rvalid0 !== 1'b0) begin errors++; $display("FAIL rd_rvalid0_drop got %b want 0", rvalid0); end
    checks++; if (rdata0 !== 32'hDEADBEEF) begin
      errors++; $display("FAIL rd_rdata0_hold got %h want deadbeef", rdata0); end
    tick();
  endtask

  task automatic test_contention();
    logic [1:0] want;
    do_reset();
    req0 = 1'b1; we0 = 1'b1; addr0 = 16'h0030; wdata0 = 32'h0000_0A0A;
    req1 = 1'b1; we1 = 1'b1; addr1 = 16'h0034; wdata1 = 32'h0000_0B0B;
    for (int i = 0; i < 4; i++) begin
`ifdef DMEM_ARB_FIXED_PRIO_EN
      want = 2'b10;
`else
      want = (i % 2 == 0) ? 2'b01 : 2'b10;
`endif
      @(negedge clk);
      checks++; if ({gnt1, gnt0} !== want) begin
        errors++; $display("FAIL cont_gnt cycle %0d got %b want %b", i, {gnt1, gnt0}, want); end
      tick();
    end
    idle();
    tick();
  endtask

  task automatic test_back_to_back();
    idle();
    req1 = 1'b1; we1 = 1'b1; addr1 = 16'h0020; wdata1 = 32'h12345678;
    @(negedge clk);
    checks++; if ({gnt1, ram_en, ram_we} !== 3'b111) begin
      errors++; $display("FAIL b2b_wr got %b want 111", {gnt1, ram_en, ram_we}); end
    checks++; if (ram_addr !== 14'h0008) begin
      errors++; $display("FAIL b2b_wr_addr got %h want 0008", ram_addr); end
    tick();
    idle();
    req0 = 1'b1; addr0 = 16'h0020;
    @(negedge clk);
    checks++; if ({gnt0, ram_en, ram_we} !== 3'b110) begin
      errors++; $display("FAIL b2b_rd got %b want 110", {gnt0, ram_en, ram_we}); end
    checks++; if ({rvalid0, rvalid1} !== 2'b00) begin
      errors++; $display("FAIL b2b_wr_norvalid got %b want 00", {rvalid0, rvalid1}); end
    tick();
    // Second read issued while the first one returns.
    addr0 = 16'h0010;
    @(negedge clk);
    checks++; if ({rvalid0, gnt0, ram_en} !== 3'b111) begin
      errors++; $display("FAIL b2b_overlap got %b want 111", {rvalid0, gnt0, ram_en}); end
    checks++; if (rdata0 !== 32'h12345678) begin
      errors++; $display("FAIL b2b_rdata0 got %h want 12345678", rdata0); end
    tick();
    idle();
    @(negedge clk);
    checks++; if ({rvalid0, rdata0} !== {1'b1, 32'hDEADBEEF}) begin
      errors++; $display("FAIL b2b_rdata0_2 got %b %h want 1 deadbeef", rvalid0, rdata0); end
    tick();
  endtask

  task automatic test_misaligned();
    idle();
    req0 = 1'b1; addr0 = 16'h0002;
    @(negedge clk);
    checks++; if ({gnt0, ram_en, err} !== 3'b100) begin
      errors++; $display("FAIL mis_gnt got %b want 100", {gnt0, ram_en, err}); end
    tick();
    we0 = 1'b1; be0 = 4'b0011; addr0 = 16'h0001; wdata0 = 32'hFFFF_FFFF;
    @(negedge clk);
    checks++; if ({err, rvalid0} !== 2'b11) begin
      errors++; $display("FAIL mis_err_rvalid got %b want 11", {err, rvalid0}); end
    checks++; if (rdata0 !== 32'h0) begin errors++; $display("FAIL mis_rdata0 got %h want 0", rdata0); end
    checks++; if ({gnt0, ram_en} !== 2'b10) begin
      errors++; $display("FAIL mis_half_gnt got %b want 10", {gnt0, ram_en}); end
    tick();
    addr0 = 16'h0002;
    @(negedge clk);
    checks++; if ({err, rvalid0} !== 2'b10) begin
      errors++; $display("FAIL mis_half_err got %b want 10", {err, rvalid0}); end
    checks++; if ({gnt0, ram_en} !== 2'b11) begin
      errors++; $display("FAIL aligned_half got %b want 11", {gnt0, ram_en}); end
    tick();
    idle();
    @(negedge clk);
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL mis_err_clear got %b want 0", err); end
    tick();
  endtask

  task automatic test_be_zero();
    idle();
    req1 = 1'b1; addr1 = 16'h0010;
    tick();
    be1 = 4'b0000;
    @(negedge clk);
    checks++; if ({rvalid1, rdata1} !== {1'b1, 32'hDEADBEEF}) begin
      errors++; $display("FAIL be0_prev got %b %h want 1 deadbeef", rvalid1, rdata1); end
    checks++; if ({gnt1, ram_en} !== 2'b10) begin
      errors++; $display("FAIL be0_gnt got %b want 10", {gnt1, ram_en}); end
    tick();
    idle();
    @(negedge clk);
    checks++; if ({rvalid1, rdata1, err} !== {1'b1, 32'h0, 1'b0}) begin
      errors++; $display("FAIL be0_ret got %b %h %b want 1 0 0", rvalid1, rdata1, err); end
    checks++; if (rvalid0 !== 1'b0) begin errors++; $display("FAIL be0_rvalid0 got %b want 0", rvalid0); end
    tick();
  endtask

  task automatic test_reset_mid_read();
    idle();
    req0 = 1'b1; addr0 = 16'h0010;
    tick();
    @(negedge clk);
    checks++; if ({gnt0, rvalid0} !== 2'b11) begin
      errors++; $display("FAIL midrst_gnt got %b want 11", {gnt0, rvalid0}); end
    rst_n = 1'b0;
    idle();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++; if ({rvalid0, rvalid1, rdata0} !== {2'b00, 32'h0}) begin
        errors++; $display("FAIL midrst_norvalid got %b%b %h want 00 0", rvalid0, rvalid1, rdata0);
      end
      tick();
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    mem[4] = 32'hDEADBEEF;
    test_reset();
    test_single_read();
    test_contention();
    test_back_to_back();
    test_misaligned();
    test_be_zero();
    test_reset_mid_read();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
